// File: rtl/adc_channel_stats_pkg.sv
// Shared types and constants for the ADC channel statistics block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: sample width, read-select enum, count saturation value and the
// channel-index width helper used by the interface and the top.
package adc_stats_pkg;

  localparam int          ADC_SAMPLE_W = 12;
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  typedef enum logic [1:0] {
    STAT_MIN = 2'd0,
    STAT_MAX = 2'd1,
    STAT_AVG = 2'd2,
    STAT_CNT = 2'd3
  } stat_sel_t;

  // Channel index width; a single-channel build still gets a 1-bit index.
  function automatic int chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/adc_channel_stats_if.sv
// Sample, clear and read-port bundle between the XADC readout and the stats block.
// Latency: n/a (wires only).
// Backpressure: none; samples are always accepted.
//
// master: sample source / register bank side. slave: adc_channel_stats.
// Signals: s_valid/s_chan/s_data sample strobe, clr/clr_all/clr_chan clear,
// rd_chan/rd_sel/rd_data read port, valid_mask per-channel "has samples".
// With ADC_STATS_ALARM_EN defined: thr_wr/thr_chan/thr_data threshold
// write port and the alarm flag vector.
interface adc_channel_stats_if
  import adc_stats_pkg::*;
#(
  parameter int NCH = 8,
  parameter int CW  = chan_w(NCH)
);

  logic           s_valid;
  logic [CW-1:0]  s_chan;
  logic [15:0]    s_data;
  logic           clr;
  logic           clr_all;
  logic [CW-1:0]  clr_chan;
  logic [CW-1:0]  rd_chan;
  logic [1:0]     rd_sel;
  logic [15:0]    rd_data;
  logic [NCH-1:0] valid_mask;
`ifdef ADC_STATS_ALARM_EN
  logic           thr_wr;
  logic [CW-1:0]  thr_chan;
  logic [11:0]    thr_data;
  logic [NCH-1:0] alarm;
`endif

  modport master (
    output s_valid, s_chan, s_data, clr, clr_all, clr_chan, rd_chan, rd_sel,
`ifdef ADC_STATS_ALARM_EN
    output thr_wr, thr_chan, thr_data,
    input  alarm,
`endif
    input  rd_data, valid_mask
  );

  modport slave (
    input  s_valid, s_chan, s_data, clr, clr_all, clr_chan, rd_chan, rd_sel,
`ifdef ADC_STATS_ALARM_EN
    input  thr_wr, thr_chan, thr_data,
    output alarm,
`endif
    output rd_data, valid_mask
  );

endinterface

// File: rtl/adc_channel_stats_lane.sv
// One channel's min/max/IIR-average/saturating-count state and its update.
// Latency: state updates on the edge that sees smp_vld_i/clr_i.
// Backpressure: none; every strobed sample is absorbed.
//
// Ports: clk, rst_n (sync, active-low), smp_vld_i/smp_x_i sample for this
// channel, clr_i clear for this channel, min_o/max_o/avg_o/cnt_o/vld_o state.
// With ADC_STATS_ALARM_EN: thr_wr_i/thr_dat_i threshold write, alarm_o flag.
module adc_stats_lane
  import adc_stats_pkg::*;
#(
  parameter int AVG_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    smp_vld_i,
  input  logic [ADC_SAMPLE_W-1:0] smp_x_i,
  input  logic                    clr_i,
`ifdef ADC_STATS_ALARM_EN
  input  logic                    thr_wr_i,
  input  logic [ADC_SAMPLE_W-1:0] thr_dat_i,
  output logic                    alarm_o,
`endif
  output logic [ADC_SAMPLE_W-1:0] min_o,
  output logic [ADC_SAMPLE_W-1:0] max_o,
  output logic [ADC_SAMPLE_W-1:0] avg_o,
  output logic [15:0]             cnt_o,
  output logic                    vld_o
);

  localparam int AW = ADC_SAMPLE_W + AVG_SHIFT;
  localparam logic [ADC_SAMPLE_W-1:0] MIN_CLR = '1;

  logic [ADC_SAMPLE_W-1:0] min_q, min_d, max_q, max_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    vld_q, vld_d;

  // State as seen after a same-edge clear; a coincident sample builds on this.
  logic [ADC_SAMPLE_W-1:0] base_min, base_max;
  logic [AW-1:0]           base_acc;
  logic [15:0]             base_cnt;
  logic                    base_vld;

  always_comb begin
    base_min = clr_i ? MIN_CLR : min_q;
    base_max = clr_i ? '0      : max_q;
    base_acc = clr_i ? '0      : acc_q;
    base_cnt = clr_i ? '0      : cnt_q;
    base_vld = clr_i ? 1'b0    : vld_q;

    min_d = base_min;
    max_d = base_max;
    acc_d = base_acc;
    cnt_d = base_cnt;
    vld_d = base_vld;

    if (smp_vld_i) begin
      if (!base_vld) begin
        // First sample seeds the IIR so avg equals x immediately.
        min_d = smp_x_i;
        max_d = smp_x_i;
        acc_d = AW'(smp_x_i) << AVG_SHIFT;
        cnt_d = 16'd1;
        vld_d = 1'b1;
      end else begin
        if (smp_x_i < base_min) min_d = smp_x_i;
        if (smp_x_i > base_max) max_d = smp_x_i;
        // acc stays below 4095<<AVG_SHIFT, so AW bits never overflow.
        acc_d = base_acc - (base_acc >> AVG_SHIFT) + AW'(smp_x_i);
        if (base_cnt != CNT_MAX) cnt_d = base_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= MIN_CLR;
      max_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
  assign avg_o = acc_q[AW-1:AVG_SHIFT];
  assign cnt_o = cnt_q;
  assign vld_o = vld_q;

`ifdef ADC_STATS_ALARM_EN
  logic [ADC_SAMPLE_W-1:0] thr_q, thr_d;
  logic                    alarm_q, alarm_d;

  always_comb begin
    thr_d   = thr_wr_i ? thr_dat_i : thr_q;
    alarm_d = alarm_q | (smp_vld_i & (smp_x_i > thr_q));
    // Clear beats a same-edge set.
    if (clr_i) alarm_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_q   <= '1;
      alarm_q <= 1'b0;
    end else begin
      thr_q   <= thr_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm_o = alarm_q;
`endif

endmodule

// File: rtl/adc_channel_stats.sv
// Per-channel ADC min/max/IIR-average/count tracker with a registered read port.
// Latency: sample -> state 2 edges, -> rd_data 3 edges; rd_data 1 edge after rd_chan/rd_sel.
// Backpressure: none; one sample per cycle is always accepted.
//
// Ports: clk, rst_n (sync, active-low), bus (adc_channel_stats_if.slave):
// sample input, clear controls, read select/data, valid_mask.
// Optional alarm feature under macro ADC_STATS_ALARM_EN adds threshold write
// port and sticky per-channel alarm flags on the same interface.
module adc_channel_stats
  import adc_stats_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int AVG_SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_channel_stats_if.slave  bus
);

  localparam int CW    = chan_w(NCH);
  // Slots cover every encodable index so out-of-range reads hit zero padding.
  localparam int NSLOT = 1 << CW;

  // Stage 1: input register; sample field is the top 12 bits of the DO word.
  logic                    s_vld_q;
  logic [CW-1:0]           s_chan_q;
  logic [ADC_SAMPLE_W-1:0] s_x_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_vld_q  <= 1'b0;
      s_chan_q <= '0;
      s_x_q    <= '0;
    end else begin
      s_vld_q  <= bus.s_valid;
      s_chan_q <= bus.s_chan;
      s_x_q    <= bus.s_data[15:4];
    end
  end

  logic [ADC_SAMPLE_W-1:0] min_a [NSLOT];
  logic [ADC_SAMPLE_W-1:0] max_a [NSLOT];
  logic [ADC_SAMPLE_W-1:0] avg_a [NSLOT];
  logic [15:0]             cnt_a [NSLOT];
  logic [NSLOT-1:0]        vld_a;
`ifdef ADC_STATS_ALARM_EN
  logic [NSLOT-1:0]        alarm_a;
`endif

  // Stage 2: per-channel lanes. Out-of-range indices match no lane.
  for (genvar n = 0; n < NSLOT; n++) begin : g_lane
    if (n < NCH) begin : g_real
      logic hit_smp, hit_clr;
      assign hit_smp = s_vld_q && (s_chan_q == CW'(n));
      assign hit_clr = bus.clr && (bus.clr_all || (bus.clr_chan == CW'(n)));
`ifdef ADC_STATS_ALARM_EN
      logic hit_thr;
      assign hit_thr = bus.thr_wr && (bus.thr_chan == CW'(n));
`endif

      adc_stats_lane #(
        .AVG_SHIFT (AVG_SHIFT)
      ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .smp_vld_i (hit_smp),
        .smp_x_i   (s_x_q),
        .clr_i     (hit_clr),
`ifdef ADC_STATS_ALARM_EN
        .thr_wr_i  (hit_thr),
        .thr_dat_i (bus.thr_data),
        .alarm_o   (alarm_a[n]),
`endif
        .min_o     (min_a[n]),
        .max_o     (max_a[n]),
        .avg_o     (avg_a[n]),
        .cnt_o     (cnt_a[n]),
        .vld_o     (vld_a[n])
      );
    end else begin : g_pad
      assign min_a[n] = '0;
      assign max_a[n] = '0;
      assign avg_a[n] = '0;
      assign cnt_a[n] = '0;
      assign vld_a[n] = 1'b0;
`ifdef ADC_STATS_ALARM_EN
      assign alarm_a[n] = 1'b0;
`endif
    end
  end

  // Read mux samples current lane state, so an update on this edge is seen next cycle.
  logic [15:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = '0;
    case (stat_sel_t'(bus.rd_sel))
      STAT_MIN: rd_data_d = 16'(min_a[bus.rd_chan]);
      STAT_MAX: rd_data_d = 16'(max_a[bus.rd_chan]);
      STAT_AVG: rd_data_d = 16'(avg_a[bus.rd_chan]);
      STAT_CNT: rd_data_d = cnt_a[bus.rd_chan];
      default:  rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.valid_mask = vld_a[NCH-1:0];
`ifdef ADC_STATS_ALARM_EN
  assign bus.alarm      = alarm_a[NCH-1:0];
`endif

endmodule

// File: tb/tb_adc_channel_stats.sv
// Directed self-checking bench for adc_channel_stats (NCH=8, AVG_SHIFT=4).
// Inputs driven 1ns after posedge, outputs sampled 1ns after posedge.
// Alarm scenarios are built only when ADC_STATS_ALARM_EN is defined.
module tb_adc_channel_stats;
  import adc_stats_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  adc_channel_stats_if #(.NCH(8)) bus ();

  adc_channel_stats #(
    .NCH       (8),
    .AVG_SHIFT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle; returns just after the stage-1 edge.
  task automatic send(input int ch, input int x);
    bus.s_valid = 1'b1;
    bus.s_chan  = 3'(ch);
    bus.s_data  = {12'(x), 4'h0};
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic read_stat(input int ch, input stat_sel_t sel, output logic [15:0] v);
    bus.rd_chan = 3'(ch);
    bus.rd_sel  = sel;
    tick();
    v = bus.rd_data;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    logic [15:0] exp_rst [4];
    exp_rst = '{16'h0FFF, 16'h0000, 16'h0000, 16'h0000};
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.rd_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h expected 0000", bus.rd_data);
    end
    n_checks++;
    if (bus.valid_mask !== 8'h00) begin
      n_fail++; $display("FAIL reset_valid_mask: got %h expected 00", bus.valid_mask);
    end
    rst_n = 1'b1;
    tick();
    for (int ch = 0; ch < 8; ch++) begin
      for (int s = 0; s < 4; s++) begin
        read_stat(ch, stat_sel_t'(s), v);
        n_checks++;
        if (v !== exp_rst[s]) begin
          n_fail++;
          $display("FAIL reset_read ch%0d sel%0d: got %h expected %h", ch, s, v, exp_rst[s]);
        end
      end
    end
  endtask

  // Sample on ch6 must appear on valid_mask after edge 2 and on rd_data after edge 3.
  task automatic test_latency();
    bus.rd_chan = 3'd6;
    bus.rd_sel  = STAT_CNT;
    tick();
    send(6, 77);
    n_checks++;
    if (bus.rd_data !== 16'd0 || bus.valid_mask[6] !== 1'b0) begin
      n_fail++; $display("FAIL latency_e1: got cnt %0d mask %b expected 0 0", bus.rd_data, bus.valid_mask[6]);
    end
    tick();
    n_checks++;
    if (bus.rd_data !== 16'd0 || bus.valid_mask[6] !== 1'b1) begin
      n_fail++; $display("FAIL latency_e2: got cnt %0d mask %b expected 0 1", bus.rd_data, bus.valid_mask[6]);
    end
    tick();
    n_checks++;
    if (bus.rd_data !== 16'd1) begin
      n_fail++; $display("FAIL latency_e3: got cnt %0d expected 1", bus.rd_data);
    end
  endtask

  // ch0: 100,300,200. acc 1600 -> 1600-100+300=1800 -> 1800-112+200=1888; avg=1888>>4=118.
  task automatic test_basic();
    logic [15:0] v;
    send(0, 100);
    send(0, 300);
    send(0, 200);
    tick();
    read_stat(0, STAT_MIN, v);
    n_checks++;
    if (v !== 16'd100) begin n_fail++; $display("FAIL basic_min: got %0d expected 100", v); end
    read_stat(0, STAT_MAX, v);
    n_checks++;
    if (v !== 16'd300) begin n_fail++; $display("FAIL basic_max: got %0d expected 300", v); end
    read_stat(0, STAT_AVG, v);
    n_checks++;
    if (v !== 16'd118) begin n_fail++; $display("FAIL basic_avg: got %0d expected 118", v); end
    read_stat(0, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd3) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 3", v); end
  endtask

  // ch1 1000, ch2 50, ch1 20 on consecutive cycles.
  // ch1 acc 16000 -> 16000-1000+20=15020; avg=938.
  task automatic test_back_to_back();
    logic [15:0] v;
    send(1, 1000);
    send(2, 50);
    send(1, 20);
    tick();
    read_stat(1, STAT_MIN, v);
    n_checks++;
    if (v !== 16'd20) begin n_fail++; $display("FAIL b2b_ch1_min: got %0d expected 20", v); end
    read_stat(1, STAT_MAX, v);
    n_checks++;
    if (v !== 16'd1000) begin n_fail++; $display("FAIL b2b_ch1_max: got %0d expected 1000", v); end
    read_stat(1, STAT_AVG, v);
    n_checks++;
    if (v !== 16'd938) begin n_fail++; $display("FAIL b2b_ch1_avg: got %0d expected 938", v); end
    read_stat(1, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL b2b_ch1_cnt: got %0d expected 2", v); end
    read_stat(2, STAT_MIN, v);
    n_checks++;
    if (v !== 16'd50) begin n_fail++; $display("FAIL b2b_ch2_min: got %0d expected 50", v); end
    read_stat(2, STAT_AVG, v);
    n_checks++;
    if (v !== 16'd50) begin n_fail++; $display("FAIL b2b_ch2_avg: got %0d expected 50", v); end
    read_stat(2, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd1) begin n_fail++; $display("FAIL b2b_ch2_cnt: got %0d expected 1", v); end
    read_stat(0, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd3) begin n_fail++; $display("FAIL b2b_ch0_cnt: got %0d expected 3", v); end
  endtask

  // ch3 holds 700, then clr ch3 coincides with the stage-2 edge of a 500 sample.
  task automatic test_clear();
    logic [15:0] v;
    send(3, 700);
    tick();
    send(3, 500);
    bus.clr      = 1'b1;
    bus.clr_all  = 1'b0;
    bus.clr_chan = 3'd3;
    tick();
    bus.clr = 1'b0;
    n_checks++;
    if (bus.valid_mask[3] !== 1'b1) begin
      n_fail++; $display("FAIL clr_hit_mask3: got %b expected 1", bus.valid_mask[3]);
    end
    read_stat(3, STAT_MIN, v);
    n_checks++;
    if (v !== 16'd500) begin n_fail++; $display("FAIL clr_hit_min: got %0d expected 500", v); end
    read_stat(3, STAT_MAX, v);
    n_checks++;
    if (v !== 16'd500) begin n_fail++; $display("FAIL clr_hit_max: got %0d expected 500", v); end
    read_stat(3, STAT_AVG, v);
    n_checks++;
    if (v !== 16'd500) begin n_fail++; $display("FAIL clr_hit_avg: got %0d expected 500", v); end
    read_stat(3, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd1) begin n_fail++; $display("FAIL clr_hit_cnt: got %0d expected 1", v); end
    // Plain clear of ch2 with no sample.
    bus.clr      = 1'b1;
    bus.clr_chan = 3'd2;
    tick();
    bus.clr = 1'b0;
    read_stat(2, STAT_MIN, v);
    n_checks++;
    if (v !== 16'h0FFF) begin n_fail++; $display("FAIL clr_ch2_min: got %h expected 0fff", v); end
    read_stat(2, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd0) begin n_fail++; $display("FAIL clr_ch2_cnt: got %0d expected 0", v); end
    read_stat(1, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd2) begin n_fail++; $display("FAIL clr_ch1_kept: got %0d expected 2", v); end
    n_checks++;
    if (bus.valid_mask !== 8'h4B) begin
      n_fail++; $display("FAIL clr_valid_mask: got %h expected 4b", bus.valid_mask);
    end
  endtask

  // 65537 back-to-back samples on ch4; count stops at FFFF.
  task automatic test_saturate();
    logic [15:0] v;
    bus.s_valid = 1'b1;
    bus.s_chan  = 3'd4;
    bus.s_data  = {12'd5, 4'h0};
    repeat (65537) tick();
    bus.s_valid = 1'b0;
    tick();
    read_stat(4, STAT_CNT, v);
    n_checks++;
    if (v !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt: got %h expected ffff", v); end
    read_stat(4, STAT_MIN, v);
    n_checks++;
    if (v !== 16'd5) begin n_fail++; $display("FAIL sat_min: got %0d expected 5", v); end
    n_checks++;
    if (bus.valid_mask !== 8'h5B) begin
      n_fail++; $display("FAIL sat_valid_mask: got %h expected 5b", bus.valid_mask);
    end
  endtask

`ifdef ADC_STATS_ALARM_EN
  task automatic test_alarm();
    bus.thr_wr   = 1'b1;
    bus.thr_chan = 3'd5;
    bus.thr_data = 12'd2000;
    tick();
    bus.thr_wr = 1'b0;
    send(5, 1999);
    tick();
    n_checks++;
    if (bus.alarm[5] !== 1'b0) begin n_fail++; $display("FAIL alarm_1999: got %b expected 0", bus.alarm[5]); end
    send(5, 2001);
    tick();
    n_checks++;
    if (bus.alarm[5] !== 1'b1) begin n_fail++; $display("FAIL alarm_2001: got %b expected 1", bus.alarm[5]); end
    send(5, 100);
    tick();
    n_checks++;
    if (bus.alarm !== 8'h20) begin n_fail++; $display("FAIL alarm_sticky: got %h expected 20", bus.alarm); end
  endtask
`endif

  // clr_all coincident with the stage-2 edge of a ch0 sample of 42.
  task automatic test_clr_all();
    logic [15:0] v;
    send(0, 42);
    bus.clr     = 1'b1;
    bus.clr_all = 1'b1;
    tick();
    bus.clr     = 1'b0;
    bus.clr_all = 1'b0;
    n_checks++;
    if (bus.valid_mask !== 8'h01) begin
      n_fail++; $display("FAIL clr_all_mask: got %h expected 01", bus.valid_mask);
    end
`ifdef ADC_STATS_ALARM_EN
    n_checks++;
    if (bus.alarm !== 8'h00) begin n_fail++; $display("FAIL clr_all_alarm: got %h expected 00", bus.alarm); end
`endif
    read_stat(0, STAT_MAX, v);
    n_checks++;
    if (v !== 16'd42) begin n_fail++; $display("FAIL clr_all_ch0_max: got %0d expected 42", v); end
    read_stat(0, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd1) begin n_fail++; $display("FAIL clr_all_ch0_cnt: got %0d expected 1", v); end
    read_stat(4, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd0) begin n_fail++; $display("FAIL clr_all_ch4_cnt: got %0d expected 0", v); end
    read_stat(3, STAT_MIN, v);
    n_checks++;
    if (v !== 16'h0FFF) begin n_fail++; $display("FAIL clr_all_ch3_min: got %h expected 0fff", v); end
  endtask

  // Reset lands on the stage-2 edge of a ch7 sample; nothing may be written.
  task automatic test_reset_midstream();
    logic [15:0] v;
    send(7, 9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.valid_mask !== 8'h00) begin
      n_fail++; $display("FAIL midrst_mask: got %h expected 00", bus.valid_mask);
    end
    read_stat(7, STAT_CNT, v);
    n_checks++;
    if (v !== 16'd0) begin n_fail++; $display("FAIL midrst_ch7_cnt: got %0d expected 0", v); end
    read_stat(7, STAT_MIN, v);
    n_checks++;
    if (v !== 16'h0FFF) begin n_fail++; $display("FAIL midrst_ch7_min: got %h expected 0fff", v); end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_chan   = '0;
    bus.s_data   = '0;
    bus.clr      = 1'b0;
    bus.clr_all  = 1'b0;
    bus.clr_chan = '0;
    bus.rd_chan  = '0;
    bus.rd_sel   = '0;
`ifdef ADC_STATS_ALARM_EN
    bus.thr_wr   = 1'b0;
    bus.thr_chan = '0;
    bus.thr_data = '0;
`endif
    test_reset();
    test_latency();
    test_basic();
    test_back_to_back();
    test_clear();
    test_saturate();
`ifdef ADC_STATS_ALARM_EN
    test_alarm();
`endif
    test_clr_all();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
